// File: rtl/pkt_out_arbiter.sv
// Packet-atomic round-robin arbiter: merges NUM_SRC packet sources onto one
// registered 134-bit output, with a per-grant stall watchdog.
module pkt_out_arbiter #(
  parameter  int unsigned NUM_SRC = 4,
  parameter  int unsigned TIMEOUT = 255,
  parameter  int unsigned IDW     = $clog2(NUM_SRC),
  localparam int unsigned DW      = 134
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    req_i,
  output logic [NUM_SRC-1:0]    gnt_o,
  input  logic [NUM_SRC-1:0]    data_in_valid,
  input  logic [NUM_SRC*DW-1:0] data_in,
  output logic                  data_out_valid,
  output logic [DW-1:0]         data_out,
  output logic [IDW-1:0]        gnt_id_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned WDW  = 16;
  localparam int unsigned CNTW = 16;
  localparam int unsigned SUMW = CNTW + 1;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_SNGL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]      gnt_id_q, gnt_id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]      wd_q, wd_d, wd_inc;
  logic                dvld_q, dvld_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                to_q, to_d;
  logic [CNTW-1:0]     drop_q, drop_d;

  logic [IDW-1:0]      win;
  logic                win_vld;
  int unsigned         idx;
  logic                g_vld;
  logic [DW-1:0]       g_beat;
  logic [1:0]          g_tag;
  logic                rel;
  logic                g_drop;
  logic [SUMW-1:0]     drop_sum;

  // Round-robin search starting at rr_ptr_q, ascending modulo NUM_SRC.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_SRC;
      if (!win_vld && req_i[IDW'(idx)]) begin
        win_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  assign g_vld  = data_in_valid[gnt_id_q];
  assign g_beat = data_in[32'(gnt_id_q)*DW +: DW];
  assign g_tag  = g_beat[DW-1 -: 2];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    dvld_d   = 1'b0;
    dout_d   = dout_q;
    to_d     = 1'b0;
    rel      = 1'b0;
    g_drop   = 1'b0;
    wd_inc   = wd_q + WDW'(1);

    unique case (state_q)
      S_GRANT: begin
        if (g_vld) begin
          if (g_tag == TAG_HEAD || g_tag == TAG_SNGL) begin
            dvld_d = 1'b1;
            dout_d = g_beat;
            wd_d   = '0;
            if (g_tag == TAG_SNGL) rel = 1'b1;
            else                   state_d = S_XFER;
          end else begin
            g_drop = 1'b1;
          end
        end else if (!req_i[gnt_id_q]) begin
          rel = 1'b1;
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          to_d = 1'b1;
          rel  = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_XFER: begin
        if (g_vld) begin
          dvld_d = 1'b1;
          dout_d = g_beat;
          wd_d   = '0;
          if (g_tag == TAG_TAIL || g_tag == TAG_SNGL) rel = 1'b1;
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          // Stalled mid-packet: close it downstream with a bare tail.
          to_d   = 1'b1;
          rel    = 1'b1;
          dvld_d = 1'b1;
          dout_d = {TAG_TAIL, {(DW-2){1'b0}}};
        end else begin
          wd_d = wd_inc;
        end
      end
      default: ;
    endcase

    // Release re-arbitrates in the same cycle so the grant has no bubble.
    if (state_q == S_IDLE || rel) begin
      if (win_vld) begin
        state_d  = S_GRANT;
        gnt_d    = NUM_SRC'(1) << win;
        gnt_id_d = win;
        rr_ptr_d = IDW'((32'(win) + 1) % NUM_SRC);
        wd_d     = '0;
      end else begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Drop counter: every non-granted valid beat plus bad-tag granted beats.
  always_comb begin
    drop_sum = SUMW'(drop_q) + SUMW'(g_drop);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (data_in_valid[i] && !gnt_q[i]) drop_sum = drop_sum + SUMW'(1);
    end
    drop_d = drop_sum[SUMW-1] ? '1 : drop_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      dvld_q   <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
      dvld_q   <= dvld_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      drop_q   <= drop_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign gnt_id_o       = gnt_id_q;
  assign data_out_valid = dvld_q;
  assign data_out       = dout_q;
  assign busy_o         = busy_q;
  assign timeout_o      = to_q;
  assign drop_cnt_o     = drop_q;

endmodule

// File: doc/pkt_out_arbiter.md
# pkt_out_arbiter

Packet-atomic, round-robin arbiter that merges up to NUM_SRC packet sources (configuration memory, packet memory, future packet peripherals) onto the single 134-bit packet output of the CPU user module. Sources request, receive a one-hot grant, then stream one whole packet (head..tail) that is forwarded on a registered output. A per-grant watchdog force-closes stalled packets so one faulty source cannot hold the output.

## Interface
- NUM_SRC, 4, number of packet sources (2..8).
- TIMEOUT, 255, idle cycles allowed under grant before forced release (1..65535).
- IDW, $clog2(NUM_SRC), width of gnt_id_o.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NUM_SRC  per-source packet request, level.
- gnt_o  out  NUM_SRC  one-hot grant, registered.
- data_in_valid  in  NUM_SRC  per-source beat valid.
- data_in  in  NUM_SRC*134  per-source beat; source i at [i*134+:134]; [133:132] tag: 01 head, 00 body, 10 tail, 11 single-beat head+tail.
- data_out_valid  out  1  merged beat valid, registered.
- data_out  out  134  merged beat, registered.
- gnt_id_o  out  IDW  index of current/last grantee.
- busy_o  out  1  high in GRANT or XFER.
- timeout_o  out  1  one-cycle pulse on forced release.
- drop_cnt_o  out  16  saturating count of dropped beats.

## Operation
- States: IDLE, GRANT (granted, waiting head), XFER (head seen, waiting tail).
- Arbitration: round-robin; search starts at rr_ptr, first requester in ascending-modulo order wins; rr_ptr <= winner+1 (mod NUM_SRC). Reset rr_ptr=0 (source 0 first).
- IDLE: any req_i -> set gnt_o one-hot, gnt_id_o=winner, -> GRANT.
- GRANT: granted valid beat tag 01 -> forward, -> XFER; tag 11 -> forward, release; tag 00/10 -> drop (drop_cnt++); req_i[gnt] low with no beat -> release (withdraw).
- XFER: every granted valid beat forwarded verbatim; tag 10 or 11 -> release after forwarding; tag 01 forwarded, no state change. req_i ignored.
- Release: if another (or the same, when sole) requester present, re-arbitrate same cycle -> new grant next cycle, state GRANT; else IDLE, gnt_o=0.
- Any valid beat from a non-granted source is dropped, drop_cnt++ (one per source per cycle, summed, saturating at 16'hFFFF).
- Watchdog: 16-bit counter cleared on grant and on each forwarded beat; increments each GRANT/XFER cycle without granted valid. Reaching TIMEOUT: timeout_o pulse, release. If in XFER, inject one beat: data_out = {2'b10, 132'b0} (truncation tail). In GRANT no beat injected.
- gnt_id_o holds last grantee in IDLE.

## Timing
- Reset values: gnt_o=0, data_out_valid=0, data_out=0, gnt_id_o=0, busy_o=0, timeout_o=0, drop_cnt_o=0; state IDLE; rr_ptr=0. Reset mid-packet aborts silently (no tail injected).
- req_i high at edge t in IDLE -> gnt_o valid after edge t (visible cycle t+1).
- Beat accepted at cycle t -> data_out_valid/data_out at cycle t+1; one-cycle latency, full throughput (1 beat/cycle).
- Tail at cycle t -> gnt_o switches directly to next grantee at t+1 (back-to-back packets, no idle bubble on grant).
- Source must hold req_i until its head is sent; grant withdrawal takes effect next cycle.
- Timeout injection and timeout_o assert in the cycle after the TIMEOUT-th idle cycle; new grant the same edge as release.
- Simultaneous: tail and other sources' valid in same cycle -> others dropped; granted beat and watchdog expiry same cycle -> beat wins, counter clears.

## Test plan
- Single source 1, 3-beat packet (01,00,10) after req -> gnt_o=4'b0010 next cycle, data_out identical beats, 1-cycle delay, gnt_o=0 after tail.
- req_i=4'b1111 held, each sends 2-beat packet -> grant order 0,1,2,3,0, no gap between tail and next grant.
- Source 2 sends head then stalls, TIMEOUT=8 -> after 8 idle cycles data_out={2'b10,132'b0}, timeout_o one pulse, grant moves to next requester.
- Source 3 pulses data_in_valid for 5 beats while ungranted -> all dropped, drop_cnt_o=5, data_out_valid never high.
- Single-beat tag 11 from sources 0 and 1 back-to-back -> two output beats on consecutive-grant cycles, state never in XFER.
- rst_n low mid-XFER -> all outputs zero immediately, no tail injected; first req after release granted source 0 first.
